writeback_scoreboard: RTL and testbench

Write-back stage for the pipelined CPU, at the write end of the register-file interface. It registers memory-stage results, selects the write-back value, and drives the register-file write port (A3, WE3, WD3). It also keeps a per-register scoreboard of writes that are in flight. Decode uses the scoreboard to stall when either source register (A1/A2) has a pending write.

---
 rtl/writeback_scoreboard.sv | 131 +++++++++++++
 tb/tb_writeback_scoreboard.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/writeback_scoreboard.sv
// Write-back stage: registers memory-stage results, drives the register-file write port,
// and tracks in-flight writes per register so decode can stall on pending sources.

module writeback_scoreboard_entry #(
  parameter int MAX_INFLIGHT = 3,
  parameter int CW           = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inc,
  input  logic          dec_commit,
  input  logic          dec_squash,
  output logic [CW-1:0] count,
  output logic          ovf_evt,
  output logic          unf_evt
);
  int nxt;

  // Commit and squash may both hit this entry, so the net step spans -2..+1.
  always_comb begin
    nxt     = int'(count) + int'(inc) - int'(dec_commit) - int'(dec_squash);
    ovf_evt = (nxt > MAX_INFLIGHT);
    unf_evt = (nxt < 0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)           count <= '0;
    else if (unf_evt)  count <= '0;
    else if (!ovf_evt) count <= nxt[CW-1:0];
  end
endmodule

module writeback_scoreboard #(
  parameter int ADDRESS_WIDTH = 5,
  parameter int DATA_WIDTH    = 32,
  parameter int MAX_INFLIGHT  = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     issue_valid,
  input  logic                     issue_RegWrite,
  input  logic [ADDRESS_WIDTH-1:0] issue_Rd,
  input  logic                     squash_valid,
  input  logic [ADDRESS_WIDTH-1:0] squash_Rd,
  input  logic                     mem_valid,
  input  logic                     mem_RegWrite,
  input  logic [ADDRESS_WIDTH-1:0] mem_Rd,
  input  logic [1:0]               mem_ResultSrc,
  input  logic [DATA_WIDTH-1:0]    mem_ALUResult,
  input  logic [DATA_WIDTH-1:0]    mem_ReadData,
  input  logic [DATA_WIDTH-1:0]    mem_PCPlus4,
  input  logic [ADDRESS_WIDTH-1:0] check_A1,
  input  logic [ADDRESS_WIDTH-1:0] check_A2,
  output logic [ADDRESS_WIDTH-1:0] A3,
  output logic                     WE3,
  output logic [DATA_WIDTH-1:0]    WD3,
  output logic                     stall,
  output logic                     sb_overflow,
  output logic                     sb_underflow
);
  localparam int NREG = 2**ADDRESS_WIDTH;
  localparam int CW   = $clog2(MAX_INFLIGHT+1);

  typedef struct packed {
    logic                     valid;
    logic                     reg_write;
    logic [ADDRESS_WIDTH-1:0] rd;
    logic [1:0]               result_src;
    logic [DATA_WIDTH-1:0]    alu_result;
    logic [DATA_WIDTH-1:0]    read_data;
    logic [DATA_WIDTH-1:0]    pc_plus4;
  } wb_req_t;

  wb_req_t wb;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) wb <= '0;
    else     wb <= '{valid: mem_valid, reg_write: mem_RegWrite, rd: mem_Rd,
                     result_src: mem_ResultSrc, alu_result: mem_ALUResult,
                     read_data: mem_ReadData, pc_plus4: mem_PCPlus4};
  end

  always_comb begin
    WD3 = '0;
    case (wb.result_src)
      2'b00:   WD3 = wb.alu_result;
      2'b01:   WD3 = wb.read_data;
      2'b10:   WD3 = wb.pc_plus4;
      default: WD3 = '0;
    endcase
  end

  assign A3  = wb.rd;
  assign WE3 = wb.valid & wb.reg_write & (wb.rd != '0);

  logic [NREG-1:0][CW-1:0] count;
  logic [NREG-1:0]         ovf_evt, unf_evt;

  // x0 is never tracked: it is never counted up, so squashes naming it are ignored too.
  for (genvar r = 0; r < NREG; r++) begin : g_sb
    if (r == 0) begin : g_zero
      assign count[r]   = '0;
      assign ovf_evt[r] = 1'b0;
      assign unf_evt[r] = 1'b0;
    end else begin : g_ent
      writeback_scoreboard_entry #(.MAX_INFLIGHT(MAX_INFLIGHT), .CW(CW)) u_ent (
        .clk       (clk),
        .rst       (rst),
        .inc       (issue_valid & issue_RegWrite & (issue_Rd == ADDRESS_WIDTH'(r))),
        .dec_commit(WE3 & (A3 == ADDRESS_WIDTH'(r))),
        .dec_squash(squash_valid & (squash_Rd == ADDRESS_WIDTH'(r))),
        .count     (count[r]),
        .ovf_evt   (ovf_evt[r]),
        .unf_evt   (unf_evt[r])
      );
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sb_overflow  <= 1'b0;
      sb_underflow <= 1'b0;
    end else begin
      if (|ovf_evt) sb_overflow  <= 1'b1;
      if (|unf_evt) sb_underflow <= 1'b1;
    end
  end

  // No bypass: the register file commits at the edge, so the WB cycle still stalls.
  assign stall = (count[check_A1] != '0) | (count[check_A2] != '0);
endmodule

// File: tb/tb_writeback_scoreboard.sv
// Directed bench: write-port traffic checked by a queue-driven monitor,
// stall and sticky flags checked inline against hand-computed values.

module tb_writeback_scoreboard;
  logic        clk = 1'b0;
  logic        rst;
  logic        issue_valid, issue_RegWrite, squash_valid;
  logic [4:0]  issue_Rd, squash_Rd, mem_Rd, check_A1, check_A2, A3;
  logic        mem_valid, mem_RegWrite, WE3, stall, sb_overflow, sb_underflow;
  logic [1:0]  mem_ResultSrc;
  logic [31:0] mem_ALUResult, mem_ReadData, mem_PCPlus4, WD3;

  writeback_scoreboard #(.ADDRESS_WIDTH(5), .DATA_WIDTH(32), .MAX_INFLIGHT(3)) dut (
    .clk(clk), .rst(rst),
    .issue_valid(issue_valid), .issue_RegWrite(issue_RegWrite), .issue_Rd(issue_Rd),
    .squash_valid(squash_valid), .squash_Rd(squash_Rd),
    .mem_valid(mem_valid), .mem_RegWrite(mem_RegWrite), .mem_Rd(mem_Rd),
    .mem_ResultSrc(mem_ResultSrc), .mem_ALUResult(mem_ALUResult),
    .mem_ReadData(mem_ReadData), .mem_PCPlus4(mem_PCPlus4),
    .check_A1(check_A1), .check_A2(check_A2),
    .A3(A3), .WE3(WE3), .WD3(WD3), .stall(stall),
    .sb_overflow(sb_overflow), .sb_underflow(sb_underflow)
  );

  always #5 clk = ~clk;

  typedef struct { logic [4:0] a; logic [31:0] d; } wb_exp_t;
  wb_exp_t exp_q[$];
  int total = 0;
  int bad   = 0;

  // Every write-port strobe must match the oldest expected commit.
  always @(negedge clk) begin
    if (!rst && WE3) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL wb_unexpected: got A3=%0d WD3=%h, required no write", A3, WD3);
      end else begin
        wb_exp_t e;
        e = exp_q.pop_front();
        if (A3 !== e.a || WD3 !== e.d) begin
          bad++;
          $display("FAIL wb_port: got A3=%0d WD3=%h, required A3=%0d WD3=%h", A3, WD3, e.a, e.d);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h, required %h", nm, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk); #1;
    issue_valid = 0; issue_RegWrite = 0; squash_valid = 0; mem_valid = 0; mem_RegWrite = 0;
    #1;
  endtask

  task automatic issue(input logic [4:0] rd);
    issue_valid = 1; issue_RegWrite = 1; issue_Rd = rd;
  endtask

  task automatic squash(input logic [4:0] rd);
    squash_valid = 1; squash_Rd = rd;
  endtask

  // Drive a memory-stage writer; push the expected commit unless it targets x0.
  task automatic memw(input logic [4:0] rd, input logic [1:0] src, input logic [31:0] alu,
                      input logic [31:0] ld, input logic [31:0] pc, input logic [31:0] exp_d);
    wb_exp_t e;
    mem_valid = 1; mem_RegWrite = 1; mem_Rd = rd; mem_ResultSrc = src;
    mem_ALUResult = alu; mem_ReadData = ld; mem_PCPlus4 = pc;
    if (rd != 0) begin
      e.a = rd; e.d = exp_d;
      exp_q.push_back(e);
    end
  endtask

  initial begin
    rst = 1;
    issue_valid = 0; issue_RegWrite = 0; issue_Rd = 0; squash_valid = 0; squash_Rd = 0;
    mem_valid = 0; mem_RegWrite = 0; mem_Rd = 0; mem_ResultSrc = 0;
    mem_ALUResult = 0; mem_ReadData = 0; mem_PCPlus4 = 0; check_A1 = 5; check_A2 = 7;
    cyc(); cyc();
    rst = 0;
    #1;
    chk("rst_A3", 64'(A3), 0);
    chk("rst_WE3", 64'(WE3), 0);
    chk("rst_WD3", 64'(WD3), 0);
    chk("rst_stall", 64'(stall), 0);
    chk("rst_flags", 64'({sb_overflow, sb_underflow}), 0);

    // basic load write-back to x7
    issue(7); cyc();
    chk("x7_stall_pending", 64'(stall), 1);
    memw(7, 2'b01, 32'h1111_1111, 32'hDEAD_BEEF, 32'h0, 32'hDEAD_BEEF); cyc();
    chk("x7_stall_wb_cycle", 64'(stall), 1);
    cyc();
    chk("x7_stall_after", 64'(stall), 0);

    // x0 protection
    check_A1 = 0; check_A2 = 0;
    issue(0); cyc();
    chk("x0_stall_issue", 64'(stall), 0);
    memw(0, 2'b00, 32'h1234, 32'h0, 32'h0, 32'h0); cyc();
    chk("x0_WE3", 64'(WE3), 0);
    chk("x0_stall_wb", 64'(stall), 0);
    cyc();

    // issue and commit to x3 in the same cycle
    check_A1 = 3;
    issue(3); cyc();
    memw(3, 2'b00, 32'h33, 32'h0, 32'h0, 32'h33); cyc();
    issue(3); cyc();
    chk("x3_stall_net0", 64'(stall), 1);
    cyc();
    chk("x3_stall_hold", 64'(stall), 1);
    memw(3, 2'b00, 32'h44, 32'h0, 32'h0, 32'h44); cyc();
    chk("x3_stall_wb2", 64'(stall), 1);
    cyc();
    chk("x3_stall_clear", 64'(stall), 0);

    // result mux: PC+4 and reserved encoding
    check_A1 = 12; check_A2 = 13;
    issue(12); cyc();
    issue(13); memw(12, 2'b10, 32'hA, 32'hB, 32'h104, 32'h104); cyc();
    memw(13, 2'b11, 32'h5, 32'h6, 32'h7, 32'h0); cyc();
    cyc();
    chk("mux_stall_clear", 64'(stall), 0);

    // commit and squash to x20 in one cycle count as two decrements
    check_A1 = 20; check_A2 = 0;
    issue(20); cyc();
    issue(20); cyc();
    memw(20, 2'b00, 32'h2020, 32'h0, 32'h0, 32'h2020); cyc();
    squash(20); cyc();
    chk("x20_stall_double_dec", 64'(stall), 0);
    chk("x20_flags", 64'({sb_overflow, sb_underflow}), 0);

    // saturation on x9
    check_A1 = 9;
    for (int i = 0; i < 3; i++) begin issue(9); cyc(); end
    chk("sat_no_ovf_at_max", 64'(sb_overflow), 0);
    issue(9); cyc();
    chk("sat_ovf", 64'(sb_overflow), 1);
    chk("sat_stall", 64'(stall), 1);
    for (int i = 0; i < 3; i++) begin squash(9); cyc(); end
    chk("sat_count_held_at_3", 64'(stall), 0);
    chk("sat_no_unf_yet", 64'(sb_underflow), 0);
    squash(9); cyc();
    chk("sat_unf", 64'(sb_underflow), 1);
    chk("sat_stall_after_unf", 64'(stall), 0);

    // async reset mid-stream with two x5 writes pending and one in write-back
    check_A1 = 5;
    issue(5); cyc();
    issue(5); cyc();
    memw(5, 2'b00, 32'h55, 32'h0, 32'h0, 32'h55); cyc();
    chk("pre_rst_stall", 64'(stall), 1);
    rst = 1;
    exp_q.delete();
    #1;
    chk("mid_rst_A3", 64'(A3), 0);
    chk("mid_rst_WE3", 64'(WE3), 0);
    chk("mid_rst_WD3", 64'(WD3), 0);
    chk("mid_rst_stall", 64'(stall), 0);
    chk("mid_rst_flags", 64'({sb_overflow, sb_underflow}), 0);
    cyc(); cyc();
    rst = 0;
    #1;
    chk("post_rst_stall", 64'(stall), 0);
    cyc();
    chk("post_rst_WE3", 64'(WE3), 0);

    chk("queue_drained", 64'(exp_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
